// File: rtl/dual_issue_scheduler.sv
// Dual-issue in-order scheduler: holds one even/odd instruction pair, tracks
// result latency per register with down-counters, and issues each slot to its
// pipe once its operands (and its destination, for WAW) are ready.
module dual_issue_scheduler #(
    parameter int NREG  = 128,
    parameter int LAT_W = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             ev_valid,
    input  logic [6:0]       ev_ra,
    input  logic [6:0]       ev_rb,
    input  logic [6:0]       ev_rc,
    input  logic [6:0]       ev_dst,
    input  logic             ev_rc_used,
    input  logic             ev_wr,
    input  logic [LAT_W-1:0] ev_lat,
    input  logic             od_valid,
    input  logic [6:0]       od_ra,
    input  logic [6:0]       od_rb,
    input  logic [6:0]       od_rc,
    input  logic [6:0]       od_dst,
    input  logic             od_rc_used,
    input  logic             od_wr,
    input  logic [LAT_W-1:0] od_lat,
    output logic             issue_even,
    output logic             issue_odd,
    output logic             stall,
    output logic             split,
    output logic [CNT_W-1:0] stall_cycles
);

    typedef struct packed {
        logic             valid;
        logic [6:0]       ra;
        logic [6:0]       rb;
        logic [6:0]       rc;
        logic [6:0]       dst;
        logic             rc_used;
        logic             wr;
        logic [LAT_W-1:0] lat;
    } slot_t;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_PAIR  = 2'd1,
        ST_ODD   = 2'd2
    } state_t;

    // Counter value loaded on issue; a zero latency behaves like one.
    function automatic logic [LAT_W-1:0] lat_m1(input logic [LAT_W-1:0] lat);
        if (lat == {LAT_W{1'b0}}) begin
            return {LAT_W{1'b0}};
        end else begin
            return lat - {{(LAT_W-1){1'b0}}, 1'b1};
        end
    endfunction

    state_t           state_q, state_d;
    slot_t            hold_ev_q, hold_ev_d;
    slot_t            hold_od_q, hold_od_d;
    logic [LAT_W-1:0] cnt_q [NREG];
    logic [LAT_W-1:0] cnt_d [NREG];
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    slot_t in_ev_s, in_od_s;
    logic  ev_rdy_s, od_rdy_s, intra_dep_s;
    logic  issue_even_s, issue_odd_s, stall_s, split_s, in_ready_s;
    logic  retire_s, accept_s;

    assign in_ev_s = {ev_valid, ev_ra, ev_rb, ev_rc, ev_dst, ev_rc_used, ev_wr, ev_lat};
    assign in_od_s = {od_valid, od_ra, od_rb, od_rc, od_dst, od_rc_used, od_wr, od_lat};

    // Operand/WAW readiness of both held slots and the even->odd dependence.
    always_comb begin
        ev_rdy_s = (cnt_q[hold_ev_q.ra] == {LAT_W{1'b0}})
                && (cnt_q[hold_ev_q.rb] == {LAT_W{1'b0}})
                && (!hold_ev_q.rc_used || (cnt_q[hold_ev_q.rc] == {LAT_W{1'b0}}))
                && (!hold_ev_q.wr || (cnt_q[hold_ev_q.dst] <= lat_m1(hold_ev_q.lat)));
        od_rdy_s = (cnt_q[hold_od_q.ra] == {LAT_W{1'b0}})
                && (cnt_q[hold_od_q.rb] == {LAT_W{1'b0}})
                && (!hold_od_q.rc_used || (cnt_q[hold_od_q.rc] == {LAT_W{1'b0}}))
                && (!hold_od_q.wr || (cnt_q[hold_od_q.dst] <= lat_m1(hold_od_q.lat)));
        intra_dep_s = hold_ev_q.wr
                   && ((hold_od_q.ra == hold_ev_q.dst)
                    || (hold_od_q.rb == hold_ev_q.dst)
                    || (hold_od_q.rc_used && (hold_od_q.rc == hold_ev_q.dst))
                    || (hold_od_q.wr && (hold_od_q.dst == hold_ev_q.dst)));
    end

    // Output decode: issue/stall/split/in_ready from held state only (never in_*).
    always_comb begin
        issue_even_s = 1'b0;
        issue_odd_s  = 1'b0;
        stall_s      = 1'b0;
        split_s      = 1'b0;
        retire_s     = 1'b0;
        in_ready_s   = 1'b0;
        if (reset && !flush) begin
            case (state_q)
                ST_EMPTY: begin
                    in_ready_s = 1'b1;
                end
                ST_PAIR: begin
                    if (hold_ev_q.valid) begin
                        if (ev_rdy_s) begin
                            issue_even_s = 1'b1;
                            if (hold_od_q.valid && od_rdy_s && !intra_dep_s) begin
                                issue_odd_s = 1'b1;
                            end else if (hold_od_q.valid && od_rdy_s) begin
                                // odd would go but for the pair's own dependence
                                split_s = 1'b1;
                            end else begin
                                issue_odd_s = 1'b0;
                            end
                        end else begin
                            stall_s = 1'b1;
                        end
                    end else if (hold_od_q.valid) begin
                        issue_odd_s = od_rdy_s;
                        stall_s     = !od_rdy_s;
                    end else begin
                        // empty pair just retires
                        stall_s = 1'b0;
                    end
                    retire_s = (!hold_ev_q.valid || issue_even_s)
                            && (!hold_od_q.valid || issue_odd_s);
                end
                ST_ODD: begin
                    issue_odd_s = od_rdy_s;
                    stall_s     = !od_rdy_s;
                    retire_s    = od_rdy_s;
                end
                default: begin
                    in_ready_s = 1'b0;
                end
            endcase
            in_ready_s = (state_q == ST_EMPTY) || retire_s;
        end else begin
            in_ready_s = 1'b0;
        end
        accept_s = in_valid && in_ready_s;
    end

    // Next state, holding register and saturating stall counter.
    always_comb begin
        state_d     = state_q;
        hold_ev_d   = hold_ev_q;
        hold_od_d   = hold_od_q;
        stall_cnt_d = stall_cnt_q;
        if (flush) begin
            state_d   = ST_EMPTY;
            hold_ev_d = '0;
            hold_od_d = '0;
        end else if (accept_s) begin
            state_d   = ST_PAIR;
            hold_ev_d = in_ev_s;
            hold_od_d = in_od_s;
        end else if (retire_s) begin
            state_d = ST_EMPTY;
        end else if ((state_q == ST_PAIR) && issue_even_s) begin
            state_d = ST_ODD;
        end else begin
            state_d = state_q;
        end
        if (stall_s && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

    // Scoreboard: every busy counter ticks down; an issuing writer reloads its dst.
    always_comb begin
        for (int i = 0; i < NREG; i++) begin
            if (cnt_q[i] != {LAT_W{1'b0}}) begin
                cnt_d[i] = cnt_q[i] - {{(LAT_W-1){1'b0}}, 1'b1};
            end else begin
                cnt_d[i] = cnt_q[i];
            end
        end
        if (issue_even_s && hold_ev_q.wr) begin
            cnt_d[hold_ev_q.dst] = lat_m1(hold_ev_q.lat);
        end else begin
            cnt_d[0] = cnt_d[0];
        end
        if (issue_odd_s && hold_od_q.wr) begin
            cnt_d[hold_od_q.dst] = lat_m1(hold_od_q.lat);
        end else begin
            cnt_d[0] = cnt_d[0];
        end
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= ST_EMPTY;
            hold_ev_q   <= '0;
            hold_od_q   <= '0;
            stall_cnt_q <= {CNT_W{1'b0}};
            for (int i = 0; i < NREG; i++) begin
                cnt_q[i] <= {LAT_W{1'b0}};
            end
        end else begin
            state_q     <= state_d;
            hold_ev_q   <= hold_ev_d;
            hold_od_q   <= hold_od_d;
            stall_cnt_q <= stall_cnt_d;
            for (int i = 0; i < NREG; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign issue_even   = issue_even_s;
    assign issue_odd    = issue_odd_s;
    assign stall        = stall_s;
    assign split        = split_s;
    assign in_ready     = in_ready_s;
    assign stall_cycles = stall_cnt_q;

endmodule
